sha256_round_engine: RTL

//  SHA-256 compression engine: takes one 512-bit message block plus 256-bit chaining

---
 rtl/sha256_pkg.sv | 30 +++
 rtl/k_lut.sv | 18 +
 rtl/sha256_w_sched.sv | 32 +++
 rtl/sha256_round_engine.sv | 58 +++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 word size, round count, IV and the bit-mixing helper functions
// Shared by the round engine, the message schedule and the benches.
package sha256_pkg;
    localparam int WORD = 32;
    localparam int ROUNDS = 64;
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction
    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction
    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [31:0] ch(input logic [31:0] x, y, z);
        return (x & y) ^ (~x & z);
    endfunction
    function automatic logic [31:0] maj(input logic [31:0] x, y, z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction
endpackage

// File: rtl/k_lut.sv
// k_lut: SHA-256 round constant table
// Ports: addr (round index 0..63) -> k (K[addr])
module k_lut (
    input  logic [5:0]  addr,
    output logic [31:0] k
);
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    assign k = KT[addr];
endmodule

// File: rtl/sha256_w_sched.sv
// sha256_w_sched: 16-word message schedule window plus round-constant lookup
// Ports: clk, rst (async high); load latches block_in, shift advances one round;
//        addr selects K; w = W[t] (window head), k = K[addr]
module sha256_w_sched
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block_in,
    input  logic [5:0]   addr,
    output logic [31:0]  w,
    output logic [31:0]  k
);
    logic [31:0] win [16];
    logic [31:0] nw;
    // win[j] holds W[t+j], so the word entering at the tail is W[t+16]
    assign nw = small_s1(win[14]) + win[9] + small_s0(win[1]) + win[0];
    assign w = win[0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            for (int i = 0; i < 16; i++) win[i] <= '0;
        else if (load)
            for (int i = 0; i < 16; i++) win[i] <= block_in[511 - 32*i -: 32];
        else if (shift) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= nw;
        end
    end
    k_lut u_k (.addr(addr), .k(k));
endmodule

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: iterative SHA-256 compression, one round per clock
// Ports: clk, rst (async high); start (sampled when idle), block_in[511:0],
//        hash_in[255:0]; busy, done (1-cycle pulse), hash_out[255:0] (held)
module sha256_round_engine
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out
);
    state_t st, nxt;
    logic [5:0] cnt;
    logic [255:0] v, hsave, sum;
    logic [31:0] a, b, c, d, e, f, g, h, w, k, t1, t2;
    logic load, run;
    assign {a, b, c, d, e, f, g, h} = v;
    assign load = (st == IDLE) && start;
    assign run = (st == RUN);
    assign busy = (st != IDLE);
    assign t1 = h + big_s1(e) + ch(e, f, g) + k + w;
    assign t2 = big_s0(a) + maj(a, b, c);
    always_comb begin
        nxt = load ? RUN : (run && cnt == 6'd63) ? FIN : (st == FIN) ? IDLE : st;
        sum = '0;
        for (int i = 0; i < 8; i++) sum[32*i +: 32] = hsave[32*i +: 32] + v[32*i +: 32];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            cnt <= '0;
            v <= '0;
            hsave <= '0;
            hash_out <= '0;
            done <= 1'b0;
        end else begin
            st <= nxt;
            done <= (st == FIN);
            if (load) begin
                v <= hash_in;
                hsave <= hash_in;
                cnt <= '0;
            end else if (run) begin
                v <= {t1 + t2, a, b, c, d + t1, e, f, g};
                cnt <= cnt + 6'd1;
            end
            if (st == FIN) hash_out <= sum;
        end
    end
    sha256_w_sched u_w (
        .clk(clk), .rst(rst), .load(load), .shift(run),
        .block_in(block_in), .addr(cnt), .w(w), .k(k)
    );
endmodule
